// File: rtl/output_serializer_if.sv
// Handshake bundle between the matrix output serializer and its requester/consumer.
// master drives requests, the snapshot source and back-pressure; slave is the serializer.
interface output_serializer_if #(
  parameter int WORD_W    = 16,
  parameter int NUM_WORDS = 16,
  parameter int IDX_W     = 4
);
  logic                        start;
  logic                        flush;
  logic [WORD_W*NUM_WORDS-1:0] matrix_in;
  logic                        out_ready;
  logic [WORD_W-1:0]           out_word;
  logic                        out_valid;
  logic [IDX_W-1:0]            out_index;
  logic                        out_last;
  logic                        busy;
  logic                        done;

  modport master (
    output start, flush, matrix_in, out_ready,
    input  out_word, out_valid, out_index, out_last, busy, done
  );

  modport slave (
    input  start, flush, matrix_in, out_ready,
    output out_word, out_valid, out_index, out_last, busy, done
  );
endinterface

// File: rtl/output_serializer.sv
// Snapshots a DIMxDIM matrix on start and streams it one word per valid/ready transfer.
// Define TRANSPOSE_EN to stream column-major instead of row-major.
module output_serializer #(
  parameter int WORD_W    = 16,
  parameter int NUM_WORDS = 16,
  parameter int DIM       = 4,
  parameter int IDX_W     = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  output_serializer_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);
  localparam logic [IDX_W-1:0] PRE_LAST = IDX_W'(NUM_WORDS - 2);

  state_t            state_r;
  logic [IDX_W-1:0]  count_r;
  logic [WORD_W-1:0] buf_r [NUM_WORDS];
  logic              valid_r;
  logic              busy_r;
  logic              done_r;
  logic              last_r;
  logic [IDX_W-1:0]  rd_idx_s;

  // Maps the transfer count to the row-major element position being read.
  function automatic logic [IDX_W-1:0] order(input logic [IDX_W-1:0] c);
`ifdef TRANSPOSE_EN
    int unsigned ci;
    ci    = 32'(c);
    order = IDX_W'((ci % DIM) * DIM + ci / DIM);
`else
    order = c;
`endif
  endfunction

  // Output word/index mux from registered buffer and count; forced to zero when not valid.
  always_comb begin
    rd_idx_s = order(count_r);
    if (valid_r) begin
      bus.out_word  = buf_r[rd_idx_s];
      bus.out_index = rd_idx_s;
    end else begin
      bus.out_word  = {WORD_W{1'b0}};
      bus.out_index = {IDX_W{1'b0}};
    end
  end

  assign bus.out_valid = valid_r;
  assign bus.out_last  = last_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;

  // Control FSM; status flags are registered alongside the state so no input reaches them combinationally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      count_r <= {IDX_W{1'b0}};
      valid_r <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      last_r  <= 1'b0;
      for (int i = 0; i < NUM_WORDS; i++) begin
        buf_r[i] <= {WORD_W{1'b0}};
      end
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (bus.flush) begin
            state_r <= IDLE;
          end else if (bus.start) begin
            for (int i = 0; i < NUM_WORDS; i++) begin
              buf_r[i] <= bus.matrix_in[i*WORD_W +: WORD_W];
            end
            state_r <= LOAD;
            busy_r  <= 1'b1;
            count_r <= {IDX_W{1'b0}};
          end else begin
            state_r <= IDLE;
          end
        end
        LOAD: begin
          if (bus.flush) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end else begin
            state_r <= STREAM;
            valid_r <= 1'b1;
            count_r <= {IDX_W{1'b0}};
            last_r  <= 1'b0;
          end
        end
        STREAM: begin
          // A transfer coinciding with flush is taken by the consumer; nothing further to track.
          if (bus.flush) begin
            state_r <= IDLE;
            valid_r <= 1'b0;
            busy_r  <= 1'b0;
            last_r  <= 1'b0;
            count_r <= {IDX_W{1'b0}};
          end else if (bus.out_ready) begin
            if (count_r == LAST_IDX) begin
              state_r <= DONE;
              count_r <= {IDX_W{1'b0}};
              valid_r <= 1'b0;
              busy_r  <= 1'b0;
              last_r  <= 1'b0;
              done_r  <= 1'b1;
            end else begin
              count_r <= count_r + {{(IDX_W-1){1'b0}}, 1'b1};
              last_r  <= (count_r == PRE_LAST);
            end
          end else begin
            state_r <= STREAM;
          end
        end
        DONE: begin
          done_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
          count_r <= {IDX_W{1'b0}};
          valid_r <= 1'b0;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          last_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_output_serializer.sv
// Scoreboard bench for output_serializer: expected words queued at start, popped on transfers.
module tb_output_serializer;
  localparam int WORD_W    = 16;
  localparam int NUM_WORDS = 16;
  localparam int DIM       = 4;
  localparam int IDX_W     = 4;

  typedef struct packed {
    logic [15:0] word;
    logic [3:0]  index;
    logic        last;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  output_serializer_if #(.WORD_W(WORD_W), .NUM_WORDS(NUM_WORDS), .IDX_W(IDX_W)) sif();

  output_serializer #(.WORD_W(WORD_W), .NUM_WORDS(NUM_WORDS), .DIM(DIM), .IDX_W(IDX_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (sif)
  );

  function automatic int ord(input int k);
`ifdef TRANSPOSE_EN
    return (k % DIM) * DIM + k / DIM;
`else
    return k;
`endif
  endfunction

  function automatic exp_t observed();
    return {sif.out_word, sif.out_index, sif.out_last};
  endfunction

  task automatic set_matrix(input logic [15:0] base);
    for (int i = 0; i < NUM_WORDS; i++) sif.matrix_in[i*WORD_W +: WORD_W] = base + 16'(i);
  endtask

  task automatic push_stream(input logic [15:0] base);
    exp_t e;
    for (int k = 0; k < NUM_WORDS; k++) begin
      e.word  = base + 16'(ord(k));
      e.index = 4'(ord(k));
      e.last  = (k == NUM_WORDS - 1);
      sb.push_back(e);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; sif.start = 1'b0; sif.flush = 1'b0; sif.out_ready = 1'b0;
    set_matrix(16'h0100);
    repeat (2) @(negedge clk);
    vectors++;
    if ({sif.out_valid, sif.busy, sif.done, sif.out_last, sif.out_word, sif.out_index} !== 24'h0) begin
      miscompares++; $display("FAIL reset_hold: got %h expected 0", {sif.out_valid, sif.busy, sif.done, sif.out_last, sif.out_word, sif.out_index});
    end
    reset = 1'b0;
    @(negedge clk);
    vectors++;
    if ({sif.out_valid, sif.busy, sif.done, sif.out_last, sif.out_word, sif.out_index} !== 24'h0) begin
      miscompares++; $display("FAIL reset_release: got %h expected 0", {sif.out_valid, sif.busy, sif.done, sif.out_last, sif.out_word, sif.out_index});
    end
  endtask

  task automatic test_stream();
    exp_t e;
    sb.delete(); sif.out_ready = 1'b1;
    set_matrix(16'h0100); push_stream(16'h0100);
    sif.start = 1'b1; @(negedge clk); sif.start = 1'b0;
    vectors++;
    if ({sif.busy, sif.out_valid} !== 2'b10) begin
      miscompares++; $display("FAIL load_cycle: got busy,valid=%b expected 10", {sif.busy, sif.out_valid});
    end
    @(negedge clk);
    for (int k = 0; k < NUM_WORDS; k++) begin
      e = sb.pop_front();
      vectors++;
      if (sif.out_valid !== 1'b1 || observed() !== e) begin
        miscompares++; $display("FAIL stream_word[%0d]: got valid=%b %h expected valid=1 %h", k, sif.out_valid, observed(), e);
      end
      @(negedge clk);
    end
    vectors++;
    if ({sif.done, sif.busy, sif.out_valid} !== 3'b100) begin
      miscompares++; $display("FAIL done_pulse: got done,busy,valid=%b expected 100", {sif.done, sif.busy, sif.out_valid});
    end
    @(negedge clk);
    vectors++;
    if ({sif.done, sif.busy, sif.out_valid} !== 3'b000) begin
      miscompares++; $display("FAIL done_width: got done,busy,valid=%b expected 000", {sif.done, sif.busy, sif.out_valid});
    end
  endtask

  task automatic test_backpressure();
    int xfers = 0;
    int cyc = 0;
    bit seen_done = 1'b0;
    sb.delete(); sif.out_ready = 1'b0;
    set_matrix(16'h0200); push_stream(16'h0200);
    sif.start = 1'b1; @(negedge clk); sif.start = 1'b0; @(negedge clk);
    while (!seen_done && cyc < 100) begin
      if (sif.done === 1'b1) begin
        seen_done = 1'b1;
      end else begin
        if (sif.out_valid === 1'b1) begin
          vectors++;
          if (sb.size() == 0) begin
            miscompares++; $display("FAIL bp_extra: got %h expected no further word", observed());
          end else if (observed() !== sb[0]) begin
            miscompares++; $display("FAIL bp_word: got %h expected %h (cycle %0d)", observed(), sb[0], cyc);
          end
        end
        if (cyc == 6) set_matrix(16'hFF00);
        sif.out_ready = (cyc % 2 == 0);
        if (sif.out_valid === 1'b1 && sif.out_ready) begin
          if (sb.size() != 0) void'(sb.pop_front());
          xfers++;
        end
        cyc++;
        @(negedge clk);
      end
    end
    vectors++;
    if (!seen_done || xfers != NUM_WORDS || sb.size() != 0) begin
      miscompares++; $display("FAIL bp_total: got done=%0d xfers=%0d left=%0d expected done=1 xfers=16 left=0", seen_done, xfers, sb.size());
    end
    sif.out_ready = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_flush();
    exp_t e;
    sb.delete(); sif.out_ready = 1'b1;
    set_matrix(16'h0100); push_stream(16'h0100);
    sif.start = 1'b1; @(negedge clk); sif.start = 1'b0; @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      e = sb.pop_front();
      vectors++;
      if (observed() !== e) begin
        miscompares++; $display("FAIL flush_pre[%0d]: got %h expected %h", k, observed(), e);
      end
      @(negedge clk);
    end
    sif.flush = 1'b1; @(negedge clk); sif.flush = 1'b0;
    vectors++;
    if ({sif.out_valid, sif.busy, sif.done} !== 3'b000) begin
      miscompares++; $display("FAIL flush_stop: got valid,busy,done=%b expected 000", {sif.out_valid, sif.busy, sif.done});
    end
    @(negedge clk);
    vectors++;
    if ({sif.out_valid, sif.done} !== 2'b00) begin
      miscompares++; $display("FAIL flush_no_done: got valid,done=%b expected 00", {sif.out_valid, sif.done});
    end
    sb.delete();
    sif.flush = 1'b1; sif.start = 1'b1; @(negedge clk); sif.flush = 1'b0; sif.start = 1'b0;
    vectors++;
    if (sif.busy !== 1'b0) begin
      miscompares++; $display("FAIL flush_beats_start: got busy=%b expected 0", sif.busy);
    end
    push_stream(16'h0100);
    sif.start = 1'b1; @(negedge clk); sif.start = 1'b0; @(negedge clk);
    e = sb.pop_front();
    vectors++;
    if (sif.out_valid !== 1'b1 || observed() !== e) begin
      miscompares++; $display("FAIL flush_restart: got valid=%b %h expected valid=1 %h", sif.out_valid, observed(), e);
    end
    sif.flush = 1'b1; @(negedge clk); sif.flush = 1'b0;
    sb.delete(); @(negedge clk);
  endtask

  task automatic test_async_reset();
    exp_t e;
    sb.delete(); sif.out_ready = 1'b1;
    set_matrix(16'h0500); push_stream(16'h0500);
    sif.start = 1'b1; @(negedge clk); sif.start = 1'b0; @(negedge clk);
    for (int k = 0; k < 9; k++) begin
      e = sb.pop_front();
      vectors++;
      if (observed() !== e) begin
        miscompares++; $display("FAIL ares_pre[%0d]: got %h expected %h", k, observed(), e);
      end
      @(negedge clk);
    end
    #2 reset = 1'b1;
    #1;
    vectors++;
    if ({sif.out_valid, sif.busy, sif.done, sif.out_last, sif.out_word, sif.out_index} !== 24'h0) begin
      miscompares++; $display("FAIL ares_immediate: got %h expected 0", {sif.out_valid, sif.busy, sif.done, sif.out_last, sif.out_word, sif.out_index});
    end
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    vectors++;
    if ({sif.out_valid, sif.busy, sif.done} !== 3'b000) begin
      miscompares++; $display("FAIL ares_idle: got valid,busy,done=%b expected 000", {sif.out_valid, sif.busy, sif.done});
    end
    sb.delete();
  endtask

  task automatic test_start_held();
    exp_t e;
    sb.delete(); sif.out_ready = 1'b1;
    set_matrix(16'h0300); push_stream(16'h0300);
    sif.start = 1'b1; @(negedge clk);
    set_matrix(16'h0400);
    @(negedge clk);
    for (int k = 0; k < NUM_WORDS; k++) begin
      e = sb.pop_front();
      vectors++;
      if (observed() !== e) begin
        miscompares++; $display("FAIL held_word[%0d]: got %h expected %h", k, observed(), e);
      end
      @(negedge clk);
    end
    vectors++;
    if ({sif.done, sif.busy} !== 2'b10) begin
      miscompares++; $display("FAIL held_done: got done,busy=%b expected 10", {sif.done, sif.busy});
    end
    @(negedge clk);
    vectors++;
    if ({sif.busy, sif.out_valid, sif.done} !== 3'b000) begin
      miscompares++; $display("FAIL held_idle: got busy,valid,done=%b expected 000", {sif.busy, sif.out_valid, sif.done});
    end
    @(negedge clk);
    vectors++;
    if (sif.busy !== 1'b1) begin
      miscompares++; $display("FAIL held_recapture: got busy=%b expected 1", sif.busy);
    end
    sif.start = 1'b0; push_stream(16'h0400);
    @(negedge clk);
    e = sb.pop_front();
    vectors++;
    if (sif.out_valid !== 1'b1 || observed() !== e) begin
      miscompares++; $display("FAIL held_new_first: got valid=%b %h expected valid=1 %h", sif.out_valid, observed(), e);
    end
    sif.flush = 1'b1; @(negedge clk); sif.flush = 1'b0;
    sb.delete(); @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_start_held();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
